// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset PC, the nop encoding, the stage payload
// record reused by the D/E/M/W registers, and the skid-buffer occupancy encoding.
package pipe_pkg;

  localparam int          PKG_XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_IR   = 32'h0000_0000;

  // The data-memory field is called dmd because "do" is a reserved word.
  typedef struct packed {
    logic [PKG_XLEN-1:0] ir;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] ao;
    logic [PKG_XLEN-1:0] dmd;
    logic                bd;
  } stage_payload_t;

  // Encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic one-entry skid buffer for a flat payload. Handshake: a word moves on
// a clock edge where valid & ready are both high; valid never waits on ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W       = 129,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output skid_state_e  state
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         in_xfer;
  logic         out_xfer;

  // With the skid present, in_ready is a pure register output.
  assign in_ready = SKID_EN ? !skid_valid : (out_ready || !main_valid);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;
  assign out_data = main_data;
  assign state    = skid_state_e'({main_valid, skid_valid});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_xfer) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (main_valid) begin
      if (in_xfer && out_xfer) begin
        main_data <= in_data;
      end else if (in_xfer && SKID_EN) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end else if (out_xfer) begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      main_data  <= in_data;
      main_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: elastic stage over pipe_skid_buf that presents
// nop bubbles when empty, the jal link value out_pc8, flush and a stall counter.
module wb_stage_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter bit              SKID_EN  = 1'b1,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_ir,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_ao,
  input  logic [XLEN-1:0]  in_do,
  input  logic             in_bd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_ir,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc8,
  output logic [XLEN-1:0]  out_ao,
  output logic [XLEN-1:0]  out_do,
  output logic             out_bd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int W = 4 * XLEN + 1;

  logic [W-1:0]    in_data;
  logic [W-1:0]    main_data;
  skid_state_e     state;
  logic [XLEN-1:0] main_ir;
  logic [XLEN-1:0] main_pc;
  logic            main_bd;

  assign in_data = {in_ir, in_pc, in_ao, in_do, in_bd};
  assign {main_ir, main_pc, out_ao, out_do, main_bd} = main_data;

  pipe_skid_buf #(
    .W       (W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_data  (main_data),
    .state     (state)
  );

  // An empty stage must look like a nop to write-back and forwarding.
  assign out_valid = state[1];
  assign out_ir    = out_valid ? main_ir : XLEN'(NOP_IR);
  assign out_pc    = out_valid ? main_pc : RESET_PC;
  assign out_bd    = out_valid && main_bd;
  assign out_pc8   = out_pc + XLEN'(8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg: a skid-enabled instance for the main
// scenarios and a SKID_EN=0 instance for the pass-through ready path.
module tb_wb_stage_reg;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_bd, flush;
  logic [31:0] in_ir, in_pc, in_ao, in_do;
  logic        out_valid, out_ready, out_bd;
  logic [31:0] out_ir, out_pc, out_pc8, out_ao, out_do;
  logic [15:0] stall_cnt;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_bd;
  logic [31:0] n_in_ir, n_out_ir, n_out_pc, n_out_pc8, n_out_ao, n_out_do;
  logic [15:0] n_stall_cnt;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  wb_stage_reg u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_ao(in_ao), .in_do(in_do), .in_bd(in_bd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_pc8(out_pc8),
    .out_ao(out_ao), .out_do(out_do), .out_bd(out_bd),
    .stall_cnt(stall_cnt)
  );

  wb_stage_reg #(.SKID_EN(1'b0)) u_dut_noskid (
    .clk(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_ir(n_in_ir), .in_pc(32'h0000_4000), .in_ao(32'h0), .in_do(32'h0), .in_bd(1'b0),
    .flush(1'b0),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_ir(n_out_ir), .out_pc(n_out_pc), .out_pc8(n_out_pc8),
    .out_ao(n_out_ao), .out_do(n_out_do), .out_bd(n_out_bd),
    .stall_cnt(n_stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver
  task automatic offer(input logic [31:0] ir, input logic [31:0] pc);
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    in_ao    = ir ^ 32'hA5A5_0000;
    in_do    = pc ^ 32'h0000_5A5A;
    in_bd    = pc[2];
  endtask

  initial begin
    int popped;
    int next_id;
    checks = 0; failures = 0;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_ir = '0; in_pc = '0; in_ao = '0; in_do = '0; in_bd = 1'b0;
    n_in_valid = 1'b0; n_in_ir = '0; n_out_ready = 1'b0;
    repeat (3) step();

    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_ir", {32'h0, out_ir}, 64'h0);
    check("rst_out_pc", {32'h0, out_pc}, 64'h3000);
    check("rst_out_pc8", {32'h0, out_pc8}, 64'h3008);
    check("rst_out_ao_do", {out_ao, out_do}, 64'h0);
    check("rst_out_bd", {63'h0, out_bd}, 64'h0);
    check("rst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
    reset = 1'b1;
    step();
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Single transfer, one-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h3C01_0001; in_pc = 32'h3000;
    in_ao = 32'h1111_2222; in_do = 32'h3333_4444; in_bd = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_valid", {63'h0, out_valid}, 64'h1);
    check("lat_ir", {32'h0, out_ir}, 64'h3C01_0001);
    check("lat_pc8", {32'h0, out_pc8}, 64'h3008);
    check("lat_ao_do", {out_ao, out_do}, 64'h1111_2222_3333_4444);
    check("lat_bd", {63'h0, out_bd}, 64'h1);
    step();
    check("lat_drain_valid", {63'h0, out_valid}, 64'h0);
    check("lat_drain_ir", {32'h0, out_ir}, 64'h0);
    check("lat_no_stall", {48'h0, stall_cnt}, 64'h0);

    // Back-pressure: fill main then skid, third offer must be refused
    out_ready = 1'b0;
    offer(32'h0000_0001, 32'h3000);
    step();
    offer(32'h0000_0002, 32'h3004);
    step();
    check("full_in_ready", {63'h0, in_ready}, 64'h0);
    offer(32'h0000_0003, 32'h3008);
    step();
    step();
    check("full_hold_pc", {32'h0, out_pc}, 64'h3000);
    check("full_hold_ready", {63'h0, in_ready}, 64'h0);
    check("full_stall_cnt", {48'h0, stall_cnt}, 64'h3);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("order_second_pc", {32'h0, out_pc}, 64'h3004);
    check("order_second_ir", {32'h0, out_ir}, 64'h2);
    check("order_second_ao", {32'h0, out_ao}, 64'hA5A5_0002);
    check("order_ready_back", {63'h0, in_ready}, 64'h1);
    step();
    check("order_third_absent", {63'h0, out_valid}, 64'h0);
    check("order_stall_kept", {48'h0, stall_cnt}, 64'h3);

    // Flush from FULL with out_ready high and a new offer
    out_ready = 1'b0;
    offer(32'h0000_0010, 32'h3010);
    step();
    offer(32'h0000_0014, 32'h3014);
    step();
    offer(32'h0000_0018, 32'h3018);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {63'h0, out_valid}, 64'h0);
    check("flush_ir", {32'h0, out_ir}, 64'h0);
    check("flush_pc", {32'h0, out_pc}, 64'h3000);
    check("flush_in_ready", {63'h0, in_ready}, 64'h1);
    check("flush_stall_kept", {48'h0, stall_cnt}, 64'h4);
    step();
    check("flush_drop_offer", {63'h0, out_valid}, 64'h0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    offer(32'h0000_0020, 32'h3020);
    step();
    offer(32'h0000_0024, 32'h3024);
    step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("areset_valid", {63'h0, out_valid}, 64'h0);
    check("areset_pc", {32'h0, out_pc}, 64'h3000);
    check("areset_ir", {32'h0, out_ir}, 64'h0);
    check("areset_stall", {48'h0, stall_cnt}, 64'h0);
    check("areset_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    reset = 1'b1;
    step();

    // PC wrap and stall counter saturation
    out_ready = 1'b1;
    offer(32'h0000_0030, 32'hFFFF_FFF8);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_pc", {32'h0, out_pc}, 64'hFFFF_FFF8);
    check("wrap_pc8", {32'h0, out_pc8}, 64'h0);
    repeat (65534) step();
    check("sat_below", {48'h0, stall_cnt}, 64'hFFFE);
    repeat (7) step();
    check("sat_hold", {48'h0, stall_cnt}, 64'hFFFF);
    check("sat_still_valid", {63'h0, out_valid}, 64'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // SKID_EN=0: in_ready follows out_ready; scoreboard checks order
    popped = 0; next_id = 0;
    n_in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && popped < 100; cyc++) begin
      n_out_ready = cyc[0];
      n_in_ir = 32'hC000_0000 | 32'(next_id);
      #1;
      check("noskid_in_ready", {63'h0, n_in_ready}, {63'h0, n_out_ready | !n_out_valid});
      if (n_out_valid && n_out_ready) begin
        if (exp_q.size() == 0) begin
          check("noskid_dup", 64'h1, 64'h0);
        end else begin
          check("noskid_data", {32'h0, n_out_ir}, {32'h0, exp_q.pop_front()});
        end
        popped++;
      end
      if (n_in_valid && n_in_ready) begin
        exp_q.push_back(n_in_ir);
        next_id++;
      end
      step();
    end
    n_in_valid = 1'b0;
    check("noskid_count", 64'(popped), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- Next-generation MEM→WB pipeline register for the pipelined MIPS core.
- Generalises the fixed 32-bit IR/PC/ALU/DM latch into a parametrised elastic stage with valid/ready handshake, one-entry skid buffer, flush and a stall-cycle counter.
- Sits between the M stage (data memory / multiply unit) and the W stage (register file write-back and forwarding).

Parameters:
- XLEN, 32, width of IR, PC, AO and DO fields.
- RESET_PC, 32'h00003000, PC value presented while the register is empty or in reset.
- SKID_EN, 1, 1 = one-entry skid buffer present; 0 = in_ready is a combinational pass-through of out_ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  M stage holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ir  in  XLEN  instruction word from M.
- in_pc  in  XLEN  PC of the instruction in M.
- in_ao  in  XLEN  ALU result from M.
- in_do  in  XLEN  data-memory read data from M.
- in_bd  in  1  instruction sits in a branch delay slot.
- flush  in  1  synchronous kill of every held entry.
- out_valid  out  1  W-stage entry valid.
- out_ready  in  1  W stage consumes this cycle.
- out_ir  out  XLEN  registered IR; 0 (nop) when out_valid=0.
- out_pc  out  XLEN  registered PC.
- out_pc8  out  XLEN  out_pc+8, the link value for jal/jalr.
- out_ao  out  XLEN  registered ALU result.
- out_do  out  XLEN  registered DM data.
- out_bd  out  1  registered delay-slot flag.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, skid empty.
  - out_ir=0, out_pc=RESET_PC, out_pc8=RESET_PC+8, out_ao=0, out_do=0, out_bd=0, stall_cnt=0.
  - in_ready=1 one cycle after release.
  - A reset mid-transfer discards both entries.
- Transfer rules:
  - Input transfer when in_valid & in_ready at the clk edge.
  - Output transfer when out_valid & out_ready.
  - Latency M→W is 1 cycle with no stall.
- States, held as {main_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1).
  - EMPTY: in_ready=1. Input transfer → ONE, main loaded.
  - ONE: in_ready=1.
    - Input and output transfer together → stay ONE, main reloaded.
    - Input only → FULL, skid loaded.
    - Output only → EMPTY.
  - FULL: in_ready=0 (registered, derived from skid_valid). Output transfer → ONE, skid moves to main.
  - SKID_EN=0: FULL is unreachable; in_ready=out_ready|!main_valid.
- Empty outputs: when main is empty, out_ir=0, out_pc=RESET_PC and out_bd=0, so a bubble is a nop.
- Flush:
  - Highest priority over every transfer.
  - Next state EMPTY, out_ir forced to 0.
  - An input offered in the same cycle is dropped.
  - stall_cnt is not cleared.
- Arithmetic:
  - out_pc8 = out_pc + 8, modulo 2^XLEN; PC 32'hFFFFFFF8 gives 0.
  - stall_cnt increments once per cycle with out_valid & !out_ready and holds at 2^CNT_W−1.
- Ordering: data stays in order; the skid entry is never presented before main.
- Other outputs: no combinational path from in_* to out_*. With SKID_EN=1, no combinational path from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - RESET_PC constant.
  - NOP_IR = 32'h00000000.
  - A typedef for the stage payload struct {ir, pc, ao, do, bd}, so the D/E/M registers reuse it.
- One sub-module, pipe_skid_buf: a generic payload skid buffer with valid/ready. wb_stage_reg wraps it and adds the reset/bubble values, out_pc8, flush and stall_cnt.

Test Plan:
- Reset release, then in_valid=1, in_ir=32'h3C010001, in_pc=32'h3000, out_ready=1 → next cycle out_valid=1, out_ir=32'h3C010001, out_pc8=32'h3008.
- Hold out_ready=0 and push 2 instructions (pc 3000, 3004) → in_ready=0 after the second. A third offered instruction is not accepted. Release out_ready → outputs 3000 then 3004 in order. stall_cnt equals the held cycles.
- FULL state plus flush=1 together with out_ready=1 → next cycle out_valid=0, out_ir=0, out_pc=32'h3000, in_ready=1.
- Assert reset while in FULL, mid-cycle → outputs return to reset values immediately, without waiting for clk.
- Drive in_pc=32'hFFFFFFF8 → out_pc8=0. Hold a stall for 2^CNT_W+5 cycles → stall_cnt=16'hFFFF.
- SKID_EN=0 build: toggle out_ready each cycle with in_valid=1 → in_ready follows out_ready in the same cycle, with no data loss or duplication over 100 transfers.
